// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
//
// APB4 initiator. It takes single-beat requests from a local valid/ready
// command port and runs each one as an APB SETUP + ACCESS transfer. Only one
// transfer is in flight at a time. Every completed transfer returns a
// one-cycle response pulse carrying the read data and error status.
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   When it is defined, a transfer is aborted after TIMEOUT_CYCLES consecutive
//   wait states. The abort returns a response with rsp_err=1 and rsp_timeout=1.
//   When it is undefined, no counter is built, ACCESS waits indefinitely, and
//   rsp_timeout is tied to 0.
//
// Parameters:
//   ADDR_W          address width (cmd_addr / paddr)
//   DATA_W          data width; the strobe buses are DATA_W/8 bits
//   TIMEOUT_CYCLES  wait states allowed before an abort (APB_TIMEOUT_EN only)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only while idle)
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_strb        command payload, captured on accept
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_err,
//   rsp_timeout                response payload, held until the next response
//   psel, penable, pwrite,
//   paddr, pwdata, pstrb       APB request signals (all registered)
//   prdata, pready, pslverr    APB completer response
module apb_master_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;

  // Reject a zero timeout at elaboration. A zero value has no meaningful
  // abort point.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic accept;
  logic done_ok;
  logic done_to;
  logic tmo_hit;

  assign accept = (state_q == IDLE) && cmd_valid;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // Completion wins over the timeout when both land on the same cycle.
        if (pready) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          done_to = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and APB/command control outputs. The outputs are
  // registered from the next state, so each one lines up with the state it
  // describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == IDLE);
      psel      <= (state_d != IDLE);
      penable   <= (state_d == ACCESS);
    end
  end

  // Request capture. The payload is held from SETUP through the last ACCESS
  // cycle and then stays put while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
      pstrb  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
    end
  end

  // Response: a single pulse the cycle after the transfer ends. The data
  // and error status are held until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done_ok | done_to;
      if (done_ok) begin
        rsp_err   <= pslverr;
        rsp_rdata <= (!pwrite && !pslverr) ? prdata : {DATA_W{1'b0}};
      end else if (done_to) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt holds the number of wait states already taken in this ACCESS.
  // The abort fires on the wait state that would make the count reach
  // TIMEOUT_CYCLES.
  assign tmo_hit = !pready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt <= '0;
    end else if ((state_q == ACCESS) && !pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_timeout <= 1'b0;
    end else if (done_to) begin
      rsp_timeout <= 1'b1;
    end else if (done_ok) begin
      rsp_timeout <= 1'b0;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int TO_CYC = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  apb_master_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .pstrb(pstrb),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference model.
  // phase counts the cycles since the accept: 0 = idle, 1 = setup, and
  // k >= 2 = the (k-1)th access cycle.
  int                phase   = 0;
  logic              m_write = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [STRB_W-1:0] m_strb  = '0;
  logic              e_rv    = 1'b0;
  logic [DATA_W-1:0] e_rdata = '0;
  logic              e_err   = 1'b0;
  logic              e_to    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; m_write = 1'b0; m_addr = '0; m_wdata = '0; m_strb = '0;
      e_rv = 1'b0; e_rdata = '0; e_err = 1'b0; e_to = 1'b0;
    end else begin
      e_rv = 1'b0;
      if (phase == 0) begin
        if (cmd_valid) begin
          m_write = cmd_write;
          m_addr  = cmd_addr;
          m_wdata = cmd_wdata;
          m_strb  = cmd_write ? cmd_strb : '0;
          phase   = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
      end else if (pready) begin
        e_rv    = 1'b1;
        e_err   = pslverr;
        e_rdata = (!m_write && !pslverr) ? prdata : '0;
        e_to    = 1'b0;
        phase   = 0;
      end else if (TO_EN && (phase - 1 == TO_CYC)) begin
        e_rv    = 1'b1;
        e_err   = 1'b1;
        e_rdata = '0;
        e_to    = 1'b1;
        phase   = 0;
      end else begin
        phase = phase + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("cmd_ready",   32'(cmd_ready),   32'(phase == 0));
    check("psel",        32'(psel),        32'(phase >= 1));
    check("penable",     32'(penable),     32'(phase >= 2));
    check("pwrite",      32'(pwrite),      32'(m_write));
    check("paddr",       32'(paddr),       32'(m_addr));
    check("pwdata",      pwdata,           m_wdata);
    check("pstrb",       32'(pstrb),       32'(m_strb));
    check("rsp_valid",   32'(rsp_valid),   32'(e_rv));
    check("rsp_rdata",   rsp_rdata,        e_rdata);
    check("rsp_err",     32'(rsp_err),     32'(e_err));
    check("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
  end

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_psel",      32'(psel),      32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write, zero wait states
    issue(1'b1, 12'h00C, 32'h1234_5678, 4'hF);
    pready = 1'b1; pslverr = 1'b0; prdata = 32'hCAFE_0000;
    @(negedge clk); // T+1
    cmd_valid = 1'b0;
    check("wr_psel_t1",    32'(psel),    32'd1);
    check("wr_penable_t1", 32'(penable), 32'd0);
    check("wr_pwrite",     32'(pwrite),  32'd1);
    check("wr_pstrb",      32'(pstrb),   32'hF);
    check("wr_paddr",      32'(paddr),   32'h00C);
    check("wr_pwdata",     pwdata,       32'h1234_5678);
    @(negedge clk); // T+2
    check("wr_penable_t2", 32'(penable), 32'd1);
    @(negedge clk); // T+3
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_err",   32'(rsp_err),   32'd0);
    check("wr_rsp_rdata", rsp_rdata,      32'd0);
    check("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    check("wr_psel_t3",   32'(psel),      32'd0);

    // Read with two wait states, accepted in the same cycle as the previous response
    issue(1'b0, 12'h004, 32'h0, 4'hF);
    pready = 1'b0; prdata = 32'hDEAD_BEEF;
    @(negedge clk); // T+1
    cmd_valid = 1'b0;
    check("rd_pstrb_setup", 32'(pstrb), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); // T+2 .. T+4
      check("rd_penable_acc", 32'(penable),   32'd1);
      check("rd_paddr_acc",   32'(paddr),     32'h004);
      check("rd_pstrb_acc",   32'(pstrb),     32'd0);
      check("rd_no_rsp_yet",  32'(rsp_valid), 32'd0);
      if (i == 2) pready = 1'b1;
    end
    @(negedge clk); // T+5
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata,      32'hDEAD_BEEF);
    check("rd_rsp_err",   32'(rsp_err),   32'd0);

    // Read that ends in a completer error
    issue(1'b0, 12'h020, 32'h0, 4'h0);
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h55AA_55AA;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); // T+3
    check("err_rsp_valid", 32'(rsp_valid), 32'd1);
    check("err_rsp_err",   32'(rsp_err),   32'd1);
    check("err_rsp_rdata", rsp_rdata,      32'd0);
    pslverr = 1'b0;

    // Second command held on cmd_valid during a transfer
    issue(1'b1, 12'h100, 32'h0000_000A, 4'h3);
    @(negedge clk); // T+1
    issue(1'b0, 12'h200, 32'h0000_000B, 4'hC);
    check("b2b_ready_t1", 32'(cmd_ready), 32'd0);
    @(negedge clk); // T+2
    check("b2b_ready_t2", 32'(cmd_ready), 32'd0);
    check("b2b_paddr_t2", 32'(paddr),     32'h100);
    @(negedge clk); // T+3
    check("b2b_ready_t3", 32'(cmd_ready), 32'd1);
    check("b2b_psel_t3",  32'(psel),      32'd0);
    @(negedge clk); // T+4
    cmd_valid = 1'b0;
    check("b2b_psel_t4",  32'(psel),   32'd1);
    check("b2b_paddr_t4", 32'(paddr),  32'h200);
    check("b2b_pwrite",   32'(pwrite), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("b2b_rsp2", 32'(rsp_valid), 32'd1);
    pready = 1'b0;

`ifdef APB_TIMEOUT_EN
    // Wait states never end, so the transfer aborts after TO_CYC access cycles
    issue(1'b0, 12'h040, 32'h0, 4'h0);
    pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk); // T+2 .. T+5
    check("to_psel_last", 32'(psel), 32'd1);
    @(negedge clk); // T+6
    check("to_psel_drop",  32'(psel),        32'd0);
    check("to_rsp_valid",  32'(rsp_valid),   32'd1);
    check("to_rsp_err",    32'(rsp_err),     32'd1);
    check("to_rsp_to",     32'(rsp_timeout), 32'd1);
    check("to_rsp_rdata",  rsp_rdata,        32'd0);
    // pready on the 4th access cycle counts as normal completion
    issue(1'b0, 12'h044, 32'h0, 4'h0);
    prdata = 32'h0BAD_F00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk); // T+2 .. T+4
    @(negedge clk); // T+5
    pready = 1'b1;
    @(negedge clk); // T+6
    check("to_edge_valid", 32'(rsp_valid),   32'd1);
    check("to_edge_to",    32'(rsp_timeout), 32'd0);
    check("to_edge_err",   32'(rsp_err),     32'd0);
    check("to_edge_rdata", rsp_rdata,        32'h0BAD_F00D);
    pready = 1'b0;
`endif

    // Reset asserted while the transfer is in ACCESS
    issue(1'b1, 12'h080, 32'h7777_7777, 4'hF);
    pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk); // T+2, access
    #2 rst_n = 1'b0;
    #1;
    check("rst_psel",      32'(psel),      32'd0);
    check("rst_penable",   32'(penable),   32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    pready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    pready = 1'b0;

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = ADDR_W'($urandom);
      cmd_wdata = $urandom;
      cmd_strb  = STRB_W'($urandom);
      pready    = ($urandom_range(0, 4) < 3);
      pslverr   = ($urandom_range(0, 7) == 0);
      prdata    = $urandom;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
